store_buffer: RTL

//  Posted-write buffer between the pipelined core's MEM-stage data port and the data RAM.
//  - Stores (mem_write) are queued in a small circular FIFO and drained to RAM in order.
//  - The core does not wait on the RAM write handshake.
//  - Loads (mem_read) read the RAM directly, with store-to-load forwarding from pending entries.
//  - Asserts stall when a store cannot be accepted or a load cannot be served correctly.

---
 rtl/store_buffer_pkg.sv | 18 +
 rtl/store_buffer_match.sv | 30 +++
 rtl/store_buffer.sv | 114 +++++++++++
 3 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types for the posted-write store buffer.
// Entry layout and pointer width are fixed here; the top-level parameters must agree.
package store_buffer_pkg;

  localparam int unsigned SbDataSize = 32;
  localparam int unsigned SbAddrSize = 10;
  localparam int unsigned SbDepth    = 4;
  localparam int unsigned SbPtrW     = $clog2(SbDepth);

  typedef logic [SbPtrW-1:0] ptr_t;

  typedef struct packed {
    logic                  valid;
    logic [SbAddrSize-1:0] addr;
    logic [SbDataSize-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_match.sv
// Youngest-first address matcher over the store buffer entries.
// Entries are scanned from tail (oldest) around to tail-1 (youngest); later hits override.
module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SbDepth
) (
  input  sb_entry_t [DEPTH-1:0]  entries_i,
  input  ptr_t                   tail_i,
  input  logic [SbAddrSize-1:0]  addr_i,
  output logic                   hit_o,
  output logic [SbDataSize-1:0]  hit_data_o
);

  ptr_t idx;

  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    idx        = tail_i;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = tail_i + ptr_t'(i);
      if (entries_i[idx].valid && (entries_i[idx].addr == addr_i)) begin
        hit_o      = 1'b1;
        hit_data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between the core MEM stage and the data RAM.
// Build option STORE_FWD_EN: store-to-load forwarding; otherwise loads hitting a pending store stall.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DATA_SIZE = SbDataSize,
  parameter int unsigned ADDR_SIZE = SbAddrSize,
  parameter int unsigned DEPTH     = SbDepth
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   mem_write,
  input  logic                   mem_read,
  input  logic [ADDR_SIZE-1:0]   daddr,
  input  logic [DATA_SIZE-1:0]   ddata_w,
  output logic [DATA_SIZE-1:0]   ddata_r,
  output logic                   stall,
  output logic                   ram_we,
  output logic [ADDR_SIZE-1:0]   ram_waddr,
  output logic [DATA_SIZE-1:0]   ram_wdata,
  input  logic                   ram_ready,
  output logic [ADDR_SIZE-1:0]   ram_raddr,
  input  logic [DATA_SIZE-1:0]   ram_rdata,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   overflow
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  sb_entry_t [DEPTH-1:0] entries_q, entries_d;
  ptr_t                  head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  overflow_q, overflow_d;

  logic                  pop, push, full_block, load_only, hit;
  logic [DATA_SIZE-1:0]  fwd_data;

  assign ram_we     = (count_q != '0);
  assign ram_waddr  = entries_q[head_q].addr;
  assign ram_wdata  = entries_q[head_q].data;
  assign ram_raddr  = daddr;
  assign occupancy  = count_q;
  assign overflow   = overflow_q;

  assign pop        = ram_we & ram_ready;
  // A full buffer still accepts a store when the head drains in the same cycle.
  assign push       = mem_write & ((count_q < CntFull) | pop);
  assign full_block = mem_write & (count_q == CntFull) & ~pop;
  assign load_only  = mem_read & ~mem_write;

  store_buffer_match #(
    .DEPTH (DEPTH)
  ) u_match (
    .entries_i  (entries_q),
    .tail_i     (tail_q),
    .addr_i     (daddr),
    .hit_o      (hit),
    .hit_data_o (fwd_data)
  );

`ifdef STORE_FWD_EN
  assign ddata_r = (hit & ~mem_write) ? fwd_data : ram_rdata;
  assign stall   = full_block;
`else
  logic unused_fwd_data;
  assign unused_fwd_data = ^fwd_data;
  assign ddata_r = ram_rdata;
  // Without forwarding, hold the load until every matching store has reached RAM.
  assign stall   = full_block | (load_only & hit);
`endif

  always_comb begin
    entries_d  = entries_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q | full_block;

    if (pop) begin
      entries_d[head_q].valid = 1'b0;
      head_d                  = head_q + ptr_t'(1);
    end
    if (push) begin
      entries_d[tail_q].valid = 1'b1;
      entries_d[tail_q].addr  = daddr;
      entries_d[tail_q].data  = ddata_w;
      tail_d                  = tail_q + ptr_t'(1);
    end

    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      entries_q  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      entries_q  <= entries_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
